// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register-file slave.
// Holds the data/strobe widths, the response encodings and the state types of the
// write and read channel FSMs.
package axil_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {WIdle, WResp} wr_state_e;
  typedef enum logic {RIdle, RResp} rd_state_e;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-strobe merge: each byte of merged comes from new_data when its strobe is set,
// otherwise from old_data. Purely combinational.
// Ports:
//   old_data  in  32  current register contents
//   new_data  in  32  incoming write data
//   strb      in  4   byte enables
//   merged    out 32  merged result
module axil_strb_merge
  import axil_pkg::*;
(
  input  logic [AXIL_DATA_W-1:0] old_data,
  input  logic [AXIL_DATA_W-1:0] new_data,
  input  logic [AXIL_STRB_W-1:0] strb,
  output logic [AXIL_DATA_W-1:0] merged
);

  always_comb begin
    merged = old_data;
    for (int k = 0; k < AXIL_STRB_W; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite slave register bank with NUM_REGS 32-bit read/write registers.
// Registers are exported flat on reg_out (reg i at [32i+31:32i]); reg_wr_pulse bit i
// strobes for one cycle after every committed write to reg i.
// Ports: clk, rst (async, active high), AXI4-Lite AW/W/B/AR/R slave channels,
//   reg_out (NUM_REGS*32), reg_wr_pulse (NUM_REGS).
// Build option: define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with
//   DECERR; otherwise they answer OKAY (writes dropped, reads return 0).
module s_axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       s_axil_awaddr,
  input  logic [2:0]                  s_axil_awprot,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]      s_axil_wdata,
  input  logic [AXIL_STRB_W-1:0]      s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]       s_axil_araddr,
  input  logic [2:0]                  s_axil_arprot,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [AXIL_DATA_W-1:0]      s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  output logic [NUM_REGS*32-1:0]      reg_out,
  output logic [NUM_REGS-1:0]         reg_wr_pulse
);

  localparam logic [ADDR_WIDTH-1:0] Base = ADDR_WIDTH'(BASE_ADDR);

`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] OorResp = RESP_DECERR;
`else
  localparam logic [1:0] OorResp = RESP_OKAY;
`endif

  // One-hot register select; all zeros means out of range.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    decode = '0;
    off    = addr - Base;
    if (addr >= Base) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((off >> 2) == ADDR_WIDTH'(i)) decode[i] = 1'b1;
      end
    end
  endfunction

  logic [2:0] unused_prot;
  assign unused_prot = s_axil_awprot ^ s_axil_arprot;

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       pulse_q, pulse_d;

  assign reg_out      = regs_q;
  assign reg_wr_pulse = pulse_q;

  // ---------------- write path ----------------
  wr_state_e                 wr_state_q, wr_state_d;
  logic                      aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]     aw_addr_q;
  logic [AXIL_DATA_W-1:0]    w_data_q;
  logic [AXIL_STRB_W-1:0]    w_strb_q;
  logic [1:0]                bresp_q;
  logic                      aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [AXIL_DATA_W-1:0]    wr_data, wr_old, wr_merged;
  logic [AXIL_STRB_W-1:0]    wr_strb;
  logic [NUM_REGS-1:0]       wsel;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  // A channel counts as present if already held or handshaking right now.
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_addr = aw_held_q ? aw_addr_q : s_axil_awaddr;
  assign wr_data = w_held_q ? w_data_q : s_axil_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_axil_wstrb;
  assign wsel    = decode(wr_addr);

  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wsel[i]) wr_old = wr_old | regs_q[i];
    end
  end

  axil_strb_merge u_merge (
    .old_data (wr_old),
    .new_data (wr_data),
    .strb     (wr_strb),
    .merged   (wr_merged)
  );

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit) begin
      pulse_d = wsel;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wsel[i]) regs_d[i] = wr_merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WIdle;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WIdle:   if (commit) wr_state_d = WResp;
      WResp:   if (s_axil_bready) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    s_axil_bvalid  = (wr_state_q == WResp);
    s_axil_bresp   = bresp_q;
    s_axil_awready = !rst && !aw_held_q && !s_axil_bvalid;
    s_axil_wready  = !rst && !w_held_q && !s_axil_bvalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      if (aw_hs) aw_addr_q <= s_axil_awaddr;
      if (w_hs) begin
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= (wsel == '0) ? OorResp : RESP_OKAY;
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs)  w_held_q  <= 1'b1;
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e              rd_state_q, rd_state_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rd_word;
  logic [1:0]             rresp_q;
  logic [NUM_REGS-1:0]    rsel;
  logic                   ar_hs;

  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign rsel  = decode(s_axil_araddr);

  // Samples regs_q, so a same-cycle write commit is not visible to this read.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsel[i]) rd_word = rd_word | regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RIdle;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RIdle:   if (ar_hs) rd_state_d = RResp;
      RResp:   if (s_axil_rready) rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    s_axil_rvalid  = (rd_state_q == RResp);
    s_axil_arready = !rst && (rd_state_q == RIdle);
    s_axil_rdata   = rdata_q;
    s_axil_rresp   = rresp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_word;
      rresp_q <= (rsel == '0) ? OorResp : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_s_axil_regfile.sv
// Self-checking bench for s_axil_regfile (default parameters). Expected B and R
// responses are queued when a transaction is issued and compared when the DUT
// completes the handshake; register contents are tracked in a local model.
module tb_s_axil_regfile;

`ifdef AXIL_REGFILE_DECERR_EN
  localparam logic [1:0] OorResp = 2'b11;
`else
  localparam logic [1:0] OorResp = 2'b00;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [3:0]   wstrb = '0;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1;
  logic [255:0] reg_out;
  logic [7:0]   reg_wr_pulse;

  logic [7:0][31:0] mdl = '0;
  logic [1:0]       b_q[$];
  rd_exp_t          r_q[$];
  int               n_checks = 0;
  int               n_errors = 0;

  always #5 clk = ~clk;

  s_axil_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_out        (reg_out),
    .reg_wr_pulse   (reg_wr_pulse)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare completed responses against the queued expectations.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (b_q.size() == 0) check_eq("b_unexpected", 1, 0);
      else check_eq("bresp", bresp, b_q.pop_front());
    end
    if (rvalid && rready) begin
      if (r_q.size() == 0) begin
        check_eq("r_unexpected", 1, 0);
      end else begin
        rd_exp_t e;
        e = r_q.pop_front();
        check_eq("rdata", rdata, e.data);
        check_eq("rresp", rresp, e.resp);
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] o, n, input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
    return m;
  endfunction

  // Full AW+W transaction with bready=1; reports how many extra cycles bvalid took.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int lat);
    logic [7:0] exp_pulse;
    logic       aw_done, w_done, aw_rdy, w_rdy;
    exp_pulse = '0;
    if (addr < 32'h20) begin
      exp_pulse[addr[4:2]] = 1'b1;
      mdl[addr[4:2]] = merge(mdl[addr[4:2]], data, strb);
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(OorResp);
    end
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
      @(negedge clk);
      aw_rdy = awready; w_rdy = wready;
      @(posedge clk); #1;
      if (awvalid && aw_rdy) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (wvalid && w_rdy)   begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) check_eq("aw_w_timeout", 1, 0);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bvalid) begin lat = t; break; end
    end
    if (lat < 0) begin
      check_eq("b_timeout", 1, 0);
    end else begin
      check_eq("wr_pulse", reg_wr_pulse, exp_pulse);
      check_eq("reg_out", reg_out, mdl);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    logic done, rdy;
    r_q.push_back('{data: exp_data, resp: exp_resp});
    araddr = addr; arvalid = 1'b1; done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      rdy = arready;
      @(posedge clk); #1;
      if (rdy) begin arvalid = 1'b0; done = 1'b1; end
    end
    if (!done) check_eq("ar_timeout", 1, 0);
    arvalid = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = rvalid;
    end
    if (!done) check_eq("r_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_reg_out", reg_out, 0);
    check_eq("rst_pulse", reg_wr_pulse, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", {awready, wready, arready}, 3'b111);

    // Same-cycle AW+W to reg 1
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, lat);
    check_eq("b_latency", lat, 0);
    check_eq("reg1", reg_out[63:32], 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("pulse_one_cycle", reg_wr_pulse, 0);
    @(posedge clk); #1;

    // W first, AW three cycles later, bready held low
    bready = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    check_eq("w_accept", wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("w_held_wready", {wready, awready}, 2'b01);
      @(posedge clk); #1;
    end
    awaddr = 32'h8; awvalid = 1'b1;
    b_q.push_back(2'b00);
    mdl[2] = 32'h0034_0078;
    @(negedge clk);
    check_eq("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check_eq("split_pulse", reg_wr_pulse, 8'b0000_0100);
    check_eq("split_reg_out", reg_out, mdl);
    for (int i = 0; i < 5; i++) begin
      check_eq("b_stall", {bvalid, awready, wready}, 3'b100);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("b_release", bvalid, 0);
    @(posedge clk); #1;

    // Read reg 1 with rready delayed
    rready = 1'b0;
    araddr = 32'h4; arvalid = 1'b1;
    r_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
    @(negedge clk);
    check_eq("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("r_stall", {rvalid, arready}, 2'b10);
      check_eq("r_stall_data", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("r_release", {rvalid, arready}, 2'b01);
    @(posedge clk); #1;

    // Out-of-range, zero strobe, last register
    do_read(32'h20, 32'h0, OorResp);
    do_write(32'h20, 32'hFFFF_FFFF, 4'hF, lat);
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, lat);
    do_write(32'h1F, 32'h0BAD_F00D, 4'b1100, lat);
    do_read(32'h1C, 32'h0BAD_0000, 2'b00);
    do_read(32'h8, 32'h0034_0078, 2'b00);

    // Same-cycle write and read of reg 0: read sees the old value
    do_write(32'h0, 32'h1, 4'hF, lat);
    fork
      do_write(32'h0, 32'hA5A5_A5A5, 4'hF, lat);
      do_read(32'h0, 32'h1, 2'b00);
    join
    do_read(32'h0, 32'hA5A5_A5A5, 2'b00);

    // Reset with both responses pending
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h8; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check_eq("pending_b_r", {bvalid, rvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_valids", {bvalid, rvalid}, 2'b00);
    check_eq("abort_regs", reg_out, 0);
    mdl = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    do_write(32'hC, 32'hCAFE_F00D, 4'hF, lat);
    check_eq("post_abort_latency", lat, 0);
    do_read(32'hC, 32'hCAFE_F00D, 2'b00);

    repeat (2) @(posedge clk);
    check_eq("sb_b_empty", b_q.size(), 0);
    check_eq("sb_r_empty", r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/s_axil_regfile.md
Name: s_axil_regfile

Overview:
- AXI4-Lite slave register bank; sits directly downstream of m_axil_adapter and terminates its AW/W/B/AR/R channels.
- Holds NUM_REGS 32-bit read/write control registers and exposes them to fabric as a flat vector.
- Emits a one-cycle write strobe per register.
- Single clock domain.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- NUM_REGS, 8, number of 32-bit registers (1..256).
- BASE_ADDR, 32'h0000_0000, byte address of register 0 (4-byte aligned).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte enables
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- reg_out  out  NUM_REGS*32  register contents; reg i at bits [32i+31:32i]
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set in the cycle after reg i is written

Behaviour:
- Reset (async assert, sync release): all registers 0, reg_out 0, reg_wr_pulse 0, bvalid 0, rvalid 0, bresp/rresp 2'b00, rdata 0. awready and wready read 0 while rst is high, 1 in the first cycle after release. arready is 0 in reset, 1 after.
- Write path, states W_IDLE / W_RESP:
  - AW and W are captured independently into holding registers.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - In the cycle when both are held (or both handshake together, or one is held while the other handshakes), commit the write: the register updates at the next edge, bvalid rises at that same edge, both held flags clear, and the FSM enters W_RESP.
  - Minimum AW+W to bvalid latency: 1 cycle.
  - W_RESP holds bvalid/bresp stable until bready, then returns to W_IDLE with bvalid=0 on the following edge. No new AW/W is accepted while bvalid=1.
- Byte strobes: byte k is updated only if wstrb[k]=1. wstrb=0 still produces a response and still pulses reg_wr_pulse.
- Address decode: idx = (addr - BASE_ADDR) >> 2, with addr[1:0] ignored. Out of range means addr < BASE_ADDR or idx >= NUM_REGS. Out-of-range writes modify nothing and pulse nothing.
- Read path, states R_IDLE / R_RESP:
  - arready = !rvalid.
  - On AR handshake, rdata = reg[idx] sampled at that edge; rvalid rises at the next edge (1-cycle latency).
  - rdata/rresp are held until rready; rvalid drops on the handshake edge. One outstanding read at most.
- Out-of-range reads return rdata=0.
- Simultaneous read and write commit to the same register in the same cycle: the read returns the pre-write value.
- Read and write paths operate concurrently and independently.
- reg_wr_pulse is registered and active for exactly one cycle per committed write.
- rst asserted mid-transaction: both FSMs abort to IDLE, held flags clear, and pending responses are dropped.

Optional Feature:
- Macro: AXIL_REGFILE_DECERR_EN.
- Defined: out-of-range accesses respond bresp/rresp = 2'b11 (DECERR).
- Undefined: out-of-range accesses respond 2'b00 (OKAY), with writes ignored and reads returning 0.
- In-range accesses always respond OKAY.

Decomposition:
- Shared package axil_pkg holds:
  - AXIL_DATA_W=32 and AXIL_STRB_W=4
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - typedefs for the write and read FSM state enums
- One sub-module, axil_strb_merge: combinational byte-strobe merge of old data, new data and wstrb. Everything else stays flat.

Test Plan:
- Reset, then AW=0x4 and W=0xDEADBEEF with wstrb=4'hF in the same cycle -> bvalid 1 cycle later with bresp=0; reg_out[63:32]=0xDEADBEEF; reg_wr_pulse=8'b0000_0010 for 1 cycle.
- W first, AW 3 cycles later (addr 0x8, data 0x12345678, wstrb=4'b0101) on reg 2 initially 0 -> reg2=0x00340078; awready=wready=0 while bvalid is held with bready=0 for 5 cycles.
- Read 0x4 after the first test with rready delayed 4 cycles -> rvalid 1 cycle after AR; rdata=0xDEADBEEF stable; arready=0 until the handshake.
- Read of 0x20 (idx 8, out of range) -> rdata=0; rresp=2'b11 with AXIL_REGFILE_DECERR_EN defined, 2'b00 without. Write to 0x20 leaves all regs unchanged and produces no pulse.
- Same-cycle write of 0xA5A5A5A5 to 0x0 and AR of 0x0, with reg0=0x1 -> rdata=0x1; the next read of 0x0 returns 0xA5A5A5A5.
- Assert rst while bvalid=1 and rvalid=1 -> both drop immediately, registers become 0, and the next write completes normally.
